// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - shared 1 ms countdown timer with round-robin requester arbitration
// The prescaler runs on CLK only; a zero-length request still shows one grant cycle before done.
module timer_arbiter #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000,
  parameter int NREQ    = 3,
  parameter int DUR_W   = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DUR_W-1:0] dur,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [DUR_W-1:0]      remaining,
  output logic                  tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int IW  = $clog2(NREQ);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_PENU = PW'(DIV - 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [PW-1:0]     presc;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     g_idx;

  logic [DUR_W-1:0]  dur_arr [NREQ];
  logic              win_valid;
  logic [IW-1:0]     win_idx;
  logic [DUR_W-1:0]  win_dur;
  int                j;

  // Search upward from ptr+1 so the last served requester ranks lowest.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_dur   = '0;
    j         = 0;
    for (int i = 0; i < NREQ; i++) begin
      dur_arr[i] = dur[i*DUR_W +: DUR_W];
    end
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!win_valid && req[j]) begin
        win_valid = 1'b1;
        win_idx   = IW'(j);
        win_dur   = dur_arr[j];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      tick      <= 1'b0;
      remaining <= '0;
      presc     <= '0;
      ptr       <= IW'(NREQ - 1);
      g_idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (win_valid) begin
            g_idx     <= win_idx;
            ptr       <= win_idx;
            grant     <= NREQ'(1) << win_idx;
            remaining <= win_dur;
            presc     <= '0;
            tick      <= 1'b0;
            if (win_dur == '0) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!req[g_idx]) begin
            state     <= IDLE;
            grant     <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            tick      <= 1'b0;
            presc     <= '0;
          end else if (presc == PRE_LAST) begin
            presc     <= '0;
            tick      <= 1'b0;
            remaining <= remaining - 1'b1;
            if (remaining == DUR_W'(1)) begin
              state <= DONE;
              grant <= '0;
              done  <= grant;
              busy  <= 1'b0;
            end
          end else begin
            presc <= presc + 1'b1;
            tick  <= (presc == PRE_PENU);
          end
        end
        DONE: begin
          // Zero-duration grants arrive here with grant still set; pulse done one cycle later.
          if (grant != '0) begin
            grant <= '0;
            done  <= grant;
          end else begin
            done  <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// tb/tb_timer_arbiter.sv - randomized and directed bench for timer_arbiter against a timeline model
module tb_timer_arbiter;
  localparam int NREQ  = 3;
  localparam int DUR_W = 8;
  localparam int DIV   = 10;

  logic                  CLK = 1'b0;
  logic                  RST_N = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*DUR_W-1:0] dur = '0;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [DUR_W-1:0]      remaining;
  logic                  tick;

  timer_arbiter #(.CLK_HZ(10), .TICK_HZ(1), .NREQ(NREQ), .DUR_W(DUR_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .req(req), .dur(dur), .grant(grant),
    .done(done), .busy(busy), .remaining(remaining), .tick(tick)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int tick_cnt = 0;
  // Model: owner of the current service, cycle index t within it (1 = first grant cycle), duration.
  int m_owner = -1;
  int m_t = 0;
  int m_d = 0;
  int m_ptr = NREQ - 1;
  int order[$];
  logic [NREQ-1:0] prev_grant = '0;
  int raise_cnt[NREQ];

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s obs=%0d exp=%0d cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic int done_t();
    return (m_d == 0) ? 2 : m_d * DIV + 1;
  endfunction

  task automatic model_step();
    bit found;
    int jj;
    found = 0;
    if (!RST_N) begin
      m_owner = -1;
      m_ptr = NREQ - 1;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        jj = (m_ptr + k) % NREQ;
        if (!found && req[jj]) begin
          found = 1;
          m_owner = jj;
          m_d = int'(dur[jj*DUR_W +: DUR_W]);
          m_t = 1;
          m_ptr = jj;
        end
      end
    end else if (m_d >= 1 && m_t <= m_d * DIV && !req[m_owner]) begin
      m_owner = -1;
    end else if (m_t == done_t()) begin
      m_owner = -1;
    end else begin
      m_t++;
    end
  endtask

  task automatic step();
    int eg, ed, eb, et, er;
    @(posedge CLK);
    model_step();
    #1;
    eg = 0; ed = 0; eb = 0; et = 0; er = 0;
    if (m_owner >= 0) begin
      if (m_t < done_t()) eg = 1 << m_owner;
      if (m_t == done_t()) ed = 1 << m_owner;
      if (m_d >= 1 && m_t <= m_d * DIV) begin
        eb = 1;
        et = (m_t % DIV == 0) ? 1 : 0;
        er = m_d - (m_t - 1) / DIV;
      end
    end
    check("grant", int'(grant), eg);
    check("done", int'(done), ed);
    check("busy", int'(busy), eb);
    check("tick", int'(tick), et);
    check("remaining", int'(remaining), er);
    if (tick) tick_cnt++;
    if (grant != '0 && grant != prev_grant) order.push_back($clog2(grant));
    prev_grant = grant;
    cyc++;
  endtask

  // mode 0: drop on done; mode 1: round-robin re-raise; mode 2: random traffic
  task automatic agent(input int mode);
    for (int i = 0; i < NREQ; i++) begin
      if (done[i]) begin
        req[i] = 1'b0;
        raise_cnt[i] = 2;
      end else if (mode == 1 && raise_cnt[i] > 0) begin
        raise_cnt[i]--;
        if (raise_cnt[i] == 0) req[i] = 1'b1;
      end else if (mode == 2) begin
        if (!req[i]) begin
          if ($urandom % 6 == 0) begin
            dur[i*DUR_W +: DUR_W] = DUR_W'($urandom % 4);
            req[i] = 1'b1;
          end
        end else if (grant[i] && $urandom % 40 == 0) begin
          req[i] = 1'b0;
        end else if ($urandom % 10 == 0) begin
          dur[i*DUR_W +: DUR_W] = DUR_W'($urandom % 4);
        end
      end
    end
    if (mode == 2) RST_N = ($urandom % 400 != 0);
  endtask

  task automatic run(input int n, input int mode);
    for (int c = 0; c < n; c++) begin
      step();
      agent(mode);
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
  endtask

  initial begin
    int exp_order[6];
    bit hit;
    for (int i = 0; i < NREQ; i++) raise_cnt[i] = 0;

    RST_N = 1'b0;
    step(); step(); step();
    RST_N = 1'b1;
    run(50, 0);

    tick_cnt = 0;
    dur[0*DUR_W +: DUR_W] = 8'd3;
    req = 3'b001;
    run(40, 0);
    check("single_ticks", tick_cnt, 3);

    tick_cnt = 0;
    dur[1*DUR_W +: DUR_W] = 8'd0;
    req = 3'b010;
    run(8, 0);
    check("zero_ticks", tick_cnt, 0);

    do_reset();
    dur = {8'd1, 8'd1, 8'd1};
    req = 3'b111;
    order.delete();
    run(80, 1);
    exp_order = '{0, 1, 2, 0, 1, 2};
    check("rr_count_ge6", (order.size() >= 6) ? 1 : 0, 1);
    for (int i = 0; i < 6; i++) begin
      if (i < order.size()) check("rr_order", order[i], exp_order[i]);
    end
    req = '0;
    for (int i = 0; i < NREQ; i++) raise_cnt[i] = 0;
    run(30, 0);

    do_reset();
    dur = {8'd2, 8'd0, 8'd5};
    req = 3'b101;
    run(17, 0);
    req[0] = 1'b0;
    run(60, 0);

    do_reset();
    dur = {8'd0, 8'd1, 8'd6};
    req = 3'b011;
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      step();
      if (remaining == 8'd4) hit = 1;
    end
    check("reach_rem4", int'(hit), 1);
    RST_N = 1'b0;
    step();
    check("rst_grant", int'(grant), 0);
    check("rst_done", int'(done), 0);
    RST_N = 1'b1;
    step();
    step();
    check("post_rst_grant", int'(grant), 1);
    req = '0;
    run(20, 0);

    run(3000, 2);
    RST_N = 1'b1;
    req = '0;
    run(60, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Shared millisecond countdown timer for the elevator controller, time-multiplexed between NREQ requesters such as the door-open hold, floor-travel timeout and display blink. It derives its own 1 ms tick enable from the system clock, so its logic runs on CLK alone and does not clock anything from divided clocks. Requesters use a req/grant/done handshake; a round-robin arbiter picks the next requester whenever the timer is idle.

## Interface
- CLK_HZ, 100_000_000, system clock frequency
- TICK_HZ, 1000, tick rate; DIV = CLK_HZ/TICK_HZ must be an integer ≥ 2
- NREQ, 3, number of requesters (2..8)
- DUR_W, 16, duration width in ticks

Ports (one clock; reset is synchronous and active-low):
- CLK  in  1  system clock, all logic on its rising edge
- RST_N  in  1  synchronous active-low reset
- req  in  NREQ  level request per requester
- dur  in  NREQ*DUR_W  duration in ticks; requester i uses bits [i*DUR_W +: DUR_W]
- grant  out  NREQ  one-hot, or zero when idle; high while the timer serves that requester
- done  out  NREQ  one-cycle pulse when the granted requester's time expires
- busy  out  1  high in RUN
- remaining  out  DUR_W  current countdown value; 0 when idle
- tick  out  1  one-cycle prescaler pulse, only in RUN

## Operation
- Prescaler: counter 0..DIV-1. It is cleared to 0 on every entry to RUN and increments only in RUN. tick = 1 in the cycle where prescaler == DIV-1, and the prescaler wraps to 0 in that cycle.
- State machine with three states: IDLE, RUN, DONE.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise, select the first set req bit searching upward from ptr+1 (mod NREQ).
  - Latch remaining = dur of the winner, set grant = onehot(winner), set ptr = winner.
  - If the latched dur == 0, go to DONE. Otherwise go to RUN.
- RUN:
  - If req[g] == 0 (requester withdrew), this is an abort: clear grant, set remaining = 0, go to IDLE, no done pulse.
  - Else on tick: remaining -= 1. If remaining was 1, clear grant and go to DONE.
  - Abort takes priority over a same-cycle final tick.
- DONE:
  - done[g] = 1 for exactly this one cycle, and grant = 0.
  - Next state is always IDLE.
- Requesters drop req on seeing done. A req still held in IDLE is re-arbitrated as a new request and takes its turn in round-robin order.
- dur is sampled only in the IDLE arbitration cycle. Later changes to dur have no effect until the next grant.
- The ptr update gives round-robin fairness: the last served requester has lowest priority in the next arbitration.
- Reset:
  - State goes to IDLE; grant, done, busy, tick, remaining and prescaler go to 0.
  - ptr goes to NREQ-1, so requester 0 has top priority first.
  - Reset mid-RUN aborts the timer immediately with no done pulse.

## Timing
- All outputs are registered.
- Request to grant: req rises and is sampled in IDLE in cycle C; grant, busy and remaining are valid in C+1.
- Duration d ≥ 1:
  - RUN starts at C+1.
  - Ticks occur at C+1+k*DIV-1 for k = 1..d.
  - done pulses in cycle C+1+d*DIV. grant drops in that same cycle.
  - Total: grant is high for exactly d*DIV cycles.
- Duration 0: grant is high for cycle C+1 only; done in C+2.
- After done: IDLE in the next cycle. The earliest next grant comes 2 cycles after done.
- Abort: req[g] is low in RUN cycle A; grant = 0 and state = IDLE in A+1.
- remaining decrements in the cycle after each tick.

## Test plan
Bench parameters are CLK_HZ=10, TICK_HZ=1 (DIV=10), NREQ=3, DUR_W=8.
- Reset, then idle, with all req low: after RST_N deasserts, grant, done, busy, tick and remaining stay 0 for 50 cycles.
- Single request: req=001 with dur0=3 in cycle 0. grant=001 from cycle 1 to 30, ticks at cycles 10/20/30, done=001 at cycle 31 only.
- Zero duration: req=010 with dur1=0. grant=010 for 1 cycle, then done=010 one cycle later, and no tick.
- Round-robin: req=111 held, with all durations 1 and each requester dropping req one cycle after its done and re-raising it 2 cycles later. Grant order must be 0,1,2,0,1,2.
- Abort: req0 granted with dur=5, req0 dropped in cycle 17. grant=0 at 18, no done, remaining=0. A pending req2 is granted at 19.
- Reset mid-operation: RST_N low during RUN with remaining=4. All outputs are 0 the next cycle with no done; after release, a held req0 is granted first.
